median_driver: RTL and testbench
================================

MEDIAN_DRIVER -- requirements
Module: median_driver

Interface
REQ-001 SHALL have parameter WIDTH, default 8, pixel width in bits.
REQ-002 SHALL have parameter N_PIXELS, default 9, pixels per window.
REQ-003 SHALL have parameter TIMEOUT, default 64, maximum cycles to wait for DSO after the last pixel.
REQ-004 SHALL have port CLK  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port nRST  input  1  synchronous, active-low reset.
REQ-006 SHALL have port WIN_VALID  input  1  upstream window valid.
REQ-007 SHALL have port WIN_READY  output  1  driver can accept a window.
REQ-008 SHALL have port WIN_DATA  input  WIDTH*N_PIXELS  window; pixel k at bits [k*WIDTH +: WIDTH].
REQ-009 SHALL have port DSI  output  1  strobe to the median engine, high while pixels are streamed.
REQ-010 SHALL have port DI  output  WIDTH  serial pixel to the median engine.
REQ-011 SHALL have port DO  input  WIDTH  median value from the engine.
REQ-012 SHALL have port DSO  input  1  engine result strobe, valid for one cycle.
REQ-013 SHALL have port RES_VALID  output  1  median result available.
REQ-014 SHALL have port RES_READY  input  1  downstream accepts result.
REQ-015 SHALL have port RES_DATA  output  WIDTH  captured median.
REQ-016 SHALL have port TIMEOUT_ERR  output  1  one-cycle pulse when DSO never arrives.

Function
REQ-017 SHALL implement FSM states IDLE, SEND, WAIT, HOLD.
REQ-018 IDLE: WIN_READY=1; a WIN_VALID&WIN_READY handshake SHALL latch WIN_DATA into an internal shift register, clear the pixel counter, and move to SEND.
REQ-019 SEND: DSI=1 and DI=pixel[cnt], registered, for exactly N_PIXELS consecutive cycles, pixel 0 first; after cnt=N_PIXELS-1, SHALL move to WAIT.
REQ-020 With the handshake in cycle T, DSI SHALL be high in cycles T+1..T+N_PIXELS and low at T+N_PIXELS+1.
REQ-021 WAIT: DSI=0; SHALL count cycles from 0; DSO=1 SHALL capture DO into RES_DATA and move to HOLD.
REQ-022 WAIT: when the counter reaches TIMEOUT-1 without DSO, SHALL pulse TIMEOUT_ERR for one cycle, leave RES_DATA unchanged, and return to IDLE.
REQ-023 DSO and timeout expiry in the same cycle: DSO SHALL win; no TIMEOUT_ERR.
REQ-024 HOLD: RES_VALID=1 with RES_DATA stable until RES_VALID&RES_READY, then IDLE; RES_VALID SHALL drop the following cycle.
REQ-025 DSO outside WAIT SHALL be ignored (no capture, no state change).
REQ-026 WIN_READY SHALL be 0 in SEND, WAIT, and HOLD; WIN_DATA changes there SHALL have no effect.
REQ-027 DI SHALL hold its last value when DSI=0; its value is don't-care.
REQ-028 Counters SHALL be sized by $clog2 of N_PIXELS and TIMEOUT; no wrap-around is reachable.
REQ-029 Latency window-accept to RES_VALID SHALL be N_PIXELS + 1 + (engine DSO delay after DSI falls) + 1 cycles.

Reset
REQ-030 On CLK edge with nRST=0: state=IDLE; DSI=0; DI=0; RES_VALID=0; RES_DATA=0; TIMEOUT_ERR=0; counters=0; WIN_READY=1 after release.
REQ-031 Reset mid-SEND SHALL drop DSI the next cycle and discard the window; a reset in WAIT or HOLD SHALL discard any pending result.

Structure
REQ-032 Package median_pkg SHALL hold the state enum type and the WIDTH/N_PIXELS default constants shared with MEDIAN.
REQ-033 A sub-module median_serializer (parallel load, shift out one pixel per cycle, done flag) SHALL be instantiated once; FSM and timeout stay in median_driver.

Verification
REQ-034 Window {9,1,8,2,7,3,6,4,5} (pixel 0=9), engine model DSO 6 cycles after DSI falls -> DI sequence 9,1,8,2,7,3,6,4,5 with DSI high exactly 9 cycles; RES_DATA=5, RES_VALID at handshake+17.
REQ-035 RES_READY held 0 for 10 cycles -> RES_VALID and RES_DATA=5 stable, WIN_READY=0 throughout; RES_READY=1 -> IDLE the next cycle.
REQ-036 Engine never asserts DSO -> TIMEOUT_ERR one-cycle pulse 64 cycles after DSI falls, RES_VALID stays 0, WIN_READY=1 the next cycle.
REQ-037 DSO coincident with the final timeout cycle, DO=0xAA -> RES_DATA=0xAA, no TIMEOUT_ERR.
REQ-038 nRST=0 at the 4th pixel of SEND -> DSI=0 the next cycle, all outputs at reset values; the next window is sent from pixel 0 correctly.
REQ-039 Spurious DSO with DO=0x33 in IDLE and SEND -> RES_DATA and state unchanged.

Source files
------------

// File: rtl/median_pkg.sv
// Shared state type and default sizes for the median engine driver.
package median_pkg;

  localparam int MEDIAN_WIDTH    = 8;
  localparam int MEDIAN_N_PIXELS = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  // Counter width for a range of n values; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/median_serializer.sv
// Loads a whole window in parallel and streams it out one pixel per cycle,
// pixel 0 first, with a strobe that is high for exactly N_PIXELS cycles.
module median_serializer
  import median_pkg::*;
#(
  parameter int WIDTH    = MEDIAN_WIDTH,
  parameter int N_PIXELS = MEDIAN_N_PIXELS
) (
  input  logic                      CLK,
  input  logic                      nRST,
  input  logic                      load,
  input  logic [WIDTH*N_PIXELS-1:0] data,
  output logic                      strobe,
  output logic [WIDTH-1:0]          pixel,
  output logic                      done
);

  localparam int             CW       = cnt_width(N_PIXELS);
  localparam logic [CW-1:0]  LAST_CNT = CW'(N_PIXELS - 1);

  logic [WIDTH*N_PIXELS-1:0] shift_reg;
  logic [CW-1:0]             cnt_reg;
  logic                      busy_reg;

  // The last pixel is not shifted away, so the output holds it once idle.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      shift_reg <= '0;
      cnt_reg   <= '0;
      busy_reg  <= 1'b0;
    end else if (load) begin
      shift_reg <= data;
      cnt_reg   <= '0;
      busy_reg  <= 1'b1;
    end else if (busy_reg) begin
      if (done) begin
        busy_reg <= 1'b0;
      end else begin
        shift_reg <= shift_reg >> WIDTH;
        cnt_reg   <= cnt_reg + 1'b1;
      end
    end
  end

  assign strobe = busy_reg;
  assign pixel  = shift_reg[WIDTH-1:0];
  assign done   = busy_reg && (cnt_reg == LAST_CNT);

endmodule

// File: rtl/median_driver.sv
// Feeds one pixel window at a time into a serial median engine and returns
// its result through a valid/ready port, with a bounded wait for the answer.
module median_driver
  import median_pkg::*;
#(
  parameter int WIDTH    = MEDIAN_WIDTH,
  parameter int N_PIXELS = MEDIAN_N_PIXELS,
  parameter int TIMEOUT  = 64
) (
  input  logic                      CLK,
  input  logic                      nRST,
  input  logic                      WIN_VALID,
  output logic                      WIN_READY,
  input  logic [WIDTH*N_PIXELS-1:0] WIN_DATA,
  output logic                      DSI,
  output logic [WIDTH-1:0]          DI,
  input  logic [WIDTH-1:0]          DO,
  input  logic                      DSO,
  output logic                      RES_VALID,
  input  logic                      RES_READY,
  output logic [WIDTH-1:0]          RES_DATA,
  output logic                      TIMEOUT_ERR
);

  localparam int            TW        = cnt_width(TIMEOUT);
  localparam logic [TW-1:0] LAST_WAIT = TW'(TIMEOUT - 1);

  state_t           state_reg, state_next;
  logic [TW-1:0]    wait_cnt_reg, wait_cnt_next;
  logic [WIDTH-1:0] res_data_reg;
  logic             timeout_err_reg;
  logic             accept, capture, expire, ser_done;

  median_serializer #(
    .WIDTH    (WIDTH),
    .N_PIXELS (N_PIXELS)
  ) u_serializer (
    .CLK    (CLK),
    .nRST   (nRST),
    .load   (accept),
    .data   (WIN_DATA),
    .strobe (DSI),
    .pixel  (DI),
    .done   (ser_done)
  );

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_reg    <= IDLE;
      wait_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  // A DSO in the final wait cycle is still a valid answer, so it is tested first.
  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = '0;
    case (state_reg)
      IDLE: if (WIN_VALID) state_next = SEND;
      SEND: if (ser_done) state_next = WAIT;
      WAIT: begin
        wait_cnt_next = wait_cnt_reg + 1'b1;
        if (DSO) begin
          state_next = HOLD;
        end else if (wait_cnt_reg == LAST_WAIT) begin
          state_next = IDLE;
        end
      end
      HOLD: if (RES_READY) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    WIN_READY = 1'b0;
    RES_VALID = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
    expire    = 1'b0;
    case (state_reg)
      IDLE: begin
        WIN_READY = 1'b1;
        accept    = WIN_VALID;
      end
      WAIT: begin
        capture = DSO;
        expire  = !DSO && (wait_cnt_reg == LAST_WAIT);
      end
      HOLD: RES_VALID = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      res_data_reg    <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      if (capture) begin
        res_data_reg <= DO;
      end
      timeout_err_reg <= expire;
    end
  end

  assign RES_DATA    = res_data_reg;
  assign TIMEOUT_ERR = timeout_err_reg;

endmodule

// File: tb/tb_median_driver.sv
// Bench for median_driver: table of windows with engine response delays,
// plus hand-written spurious-strobe and mid-stream reset sequences.
module tb_median_driver;

  localparam int W  = 8;
  localparam int NP = 9;
  localparam int TO = 64;
  localparam int DW = W * NP;

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic          WIN_VALID = 1'b0;
  logic          WIN_READY;
  logic [DW-1:0] WIN_DATA = '0;
  logic          DSI;
  logic [W-1:0]  DI;
  logic [W-1:0]  DO = '0;
  logic          DSO = 1'b0;
  logic          RES_VALID;
  logic          RES_READY = 1'b0;
  logic [W-1:0]  RES_DATA;
  logic          TIMEOUT_ERR;

  median_driver #(
    .WIDTH    (W),
    .N_PIXELS (NP),
    .TIMEOUT  (TO)
  ) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .WIN_VALID   (WIN_VALID),
    .WIN_READY   (WIN_READY),
    .WIN_DATA    (WIN_DATA),
    .DSI         (DSI),
    .DI          (DI),
    .DO          (DO),
    .DSO         (DSO),
    .RES_VALID   (RES_VALID),
    .RES_READY   (RES_READY),
    .RES_DATA    (RES_DATA),
    .TIMEOUT_ERR (TIMEOUT_ERR)
  );

  typedef struct {
    logic [DW-1:0] data;
    int            delay;     // engine DSO delay after DSI falls; -1 = never
    logic [W-1:0]  do_val;
    int            hold;      // extra cycles RES_READY stays low
    bit            expect_to;
    bit            spur;      // inject a stray DSO during SEND
  } vec_t;

  vec_t vecs [6];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [W-1:0] pix_q [$];
  logic [W-1:0] res_q [$];
  logic [W-1:0] last_res = '0;

  int   dsi_rise = -1;
  int   dsi_fall = -1;
  int   res_rise = -1;
  int   to_count = 0;
  int   to_cyc = -1;
  logic dsi_prev = 1'b0;
  logic rv_prev = 1'b0;

  initial forever #5 CLK = ~CLK;
  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: scoreboards DI and accepted results, timestamps DUT events.
  initial forever begin
    @(negedge CLK);
    if (!nRST) begin
      pix_q.delete();
      res_q.delete();
    end else begin
      if (DSI) begin
        if (pix_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL di_extra: DI=0x%0h streamed with no pixel expected (cycle %0d)", DI, cyc);
        end else begin
          check("di", DI, pix_q.pop_front());
        end
      end
      if (TIMEOUT_ERR) begin
        to_count++;
        to_cyc = cyc;
      end
      if (RES_VALID && RES_READY) begin
        if (res_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL res_extra: RES_DATA=0x%0h accepted with no result expected", RES_DATA);
        end else begin
          check("res_accept", RES_DATA, res_q.pop_front());
        end
      end
    end
    if (DSI && !dsi_prev) dsi_rise = cyc;
    if (!DSI && dsi_prev) dsi_fall = cyc;
    if (RES_VALID && !rv_prev) res_rise = cyc;
    dsi_prev = DSI;
    rv_prev  = RES_VALID;
    if (pix_q.size() > 0 || res_q.size() > 0) begin
    end
  end

  task automatic send_window(input logic [DW-1:0] data, output int hs);
    @(posedge CLK); #1;
    WIN_VALID = 1'b1;
    WIN_DATA  = data;
    hs = cyc;
    @(negedge CLK);
    check("win_ready_idle", WIN_READY, 1);
    @(posedge CLK); #1;
    WIN_VALID = 1'b0;
    WIN_DATA  = ~data;
  endtask

  task automatic run_engine(input int delay, input logic [W-1:0] val);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < NP + 20; k++) begin
      @(negedge CLK);
      if (!DSI) begin
        seen = 1'b1;
        break;
      end
    end
    check("dsi_fall_seen", seen, 1);
    if (seen && delay >= 0) begin
      if (delay > 0) repeat (delay) @(posedge CLK);
      #1;
      DO  = val;
      DSO = 1'b1;
      @(posedge CLK); #1;
      DSO = 1'b0;
    end
  endtask

  task automatic run_vector(input int idx);
    vec_t v;
    int   hs;
    int   to_before;
    bit   got;
    v = vecs[idx];
    to_before = to_count;
    for (int k = 0; k < NP; k++) pix_q.push_back(v.data[k*W +: W]);
    if (!v.expect_to) res_q.push_back(v.do_val);
    send_window(v.data, hs);
    if (v.spur) begin
      repeat (2) @(posedge CLK);
      #1;
      DO  = 8'h33;
      DSO = 1'b1;
      @(posedge CLK); #1;
      DSO = 1'b0;
      @(negedge CLK);
      check("spur_send_res_data", RES_DATA, last_res);
      check("spur_send_dsi", DSI, 1);
    end
    run_engine(v.delay, v.do_val);
    got = 1'b0;
    for (int k = 0; k < 150; k++) begin
      if (res_rise > hs || to_count != to_before) begin
        got = 1'b1;
        break;
      end
      @(posedge CLK); #1;
    end
    check("outcome_seen", got, 1);
    check("dsi_rise_offset", dsi_rise - hs, 1);
    check("dsi_fall_offset", dsi_fall - hs, NP + 1);
    if (v.expect_to) begin
      check("timeout_offset", to_cyc - hs, NP + 1 + TO);
      check("to_no_res_valid", res_rise > hs, 0);
      @(negedge CLK);
      check("to_pulse_end", TIMEOUT_ERR, 0);
      check("to_win_ready", WIN_READY, 1);
      check("to_res_valid", RES_VALID, 0);
      check("to_res_data", RES_DATA, last_res);
      @(posedge CLK); #1;
      check("to_pulse_count", to_count - to_before, 1);
    end else begin
      check("latency", res_rise - hs, NP + 1 + v.delay + 1);
      check("no_timeout", to_count - to_before, 0);
      @(negedge CLK);
      check("res_data", RES_DATA, v.do_val);
      check("win_ready_busy", WIN_READY, 0);
      for (int k = 0; k < v.hold; k++) begin
        @(negedge CLK);
        check("hold_valid", RES_VALID, 1);
        check("hold_data", RES_DATA, v.do_val);
        check("hold_win_ready", WIN_READY, 0);
      end
      @(posedge CLK); #1;
      RES_READY = 1'b1;
      @(posedge CLK); #1;
      RES_READY = 1'b0;
      @(negedge CLK);
      check("res_valid_drop", RES_VALID, 0);
      check("idle_win_ready", WIN_READY, 1);
      last_res = v.do_val;
    end
    $display("vector %0d: handshake cycle %0d delay %0d done (checks=%0d)", idx, hs, v.delay, checks);
  endtask

  initial begin
    int hs;

    vecs[0] = '{data: {8'd5, 8'd4, 8'd6, 8'd3, 8'd7, 8'd2, 8'd8, 8'd1, 8'd9},
                delay: 6, do_val: 8'd5, hold: 10, expect_to: 1'b0, spur: 1'b0};
    vecs[1] = '{data: {8'h80, 8'hFF, 8'h00, 8'h7F, 8'h01, 8'hFE, 8'h55, 8'hAA, 8'h3C},
                delay: 0, do_val: 8'h11, hold: 1, expect_to: 1'b0, spur: 1'b0};
    vecs[2] = '{data: {8'h19, 8'h28, 8'h37, 8'h46, 8'h55, 8'h64, 8'h73, 8'h82, 8'h91},
                delay: TO - 1, do_val: 8'hAA, hold: 2, expect_to: 1'b0, spur: 1'b0};
    vecs[3] = '{data: {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09},
                delay: -1, do_val: 8'hEE, hold: 0, expect_to: 1'b1, spur: 1'b0};
    vecs[4] = '{data: {8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5, 8'h96, 8'h87, 8'h78},
                delay: TO, do_val: 8'h44, hold: 0, expect_to: 1'b1, spur: 1'b0};
    vecs[5] = '{data: {8'h0F, 8'h1E, 8'h2D, 8'h3C, 8'h4B, 8'h5A, 8'h69, 8'h78, 8'h87},
                delay: 2, do_val: 8'h77, hold: 3, expect_to: 1'b0, spur: 1'b1};

    // Reset state
    nRST = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_dsi", DSI, 0);
    check("rst_di", DI, 0);
    check("rst_res_valid", RES_VALID, 0);
    check("rst_res_data", RES_DATA, 0);
    check("rst_timeout_err", TIMEOUT_ERR, 0);
    @(posedge CLK); #1;
    nRST = 1'b1;
    @(negedge CLK);
    check("rel_win_ready", WIN_READY, 1);
    $display("reset sequence done (checks=%0d)", checks);

    for (int i = 0; i < 6; i++) run_vector(i);

    // Stray DSO while idle
    @(posedge CLK); #1;
    DO  = 8'h33;
    DSO = 1'b1;
    @(posedge CLK); #1;
    DSO = 1'b0;
    @(negedge CLK);
    check("spur_idle_res_data", RES_DATA, last_res);
    check("spur_idle_res_valid", RES_VALID, 0);
    check("spur_idle_win_ready", WIN_READY, 1);
    $display("idle stray DSO sequence done (checks=%0d)", checks);

    // Reset while the 4th pixel is on DI
    for (int k = 0; k < NP; k++) pix_q.push_back(vecs[1].data[k*W +: W]);
    send_window(vecs[1].data, hs);
    repeat (3) @(posedge CLK);
    #1;
    nRST = 1'b0;
    @(posedge CLK); #1;
    nRST = 1'b1;
    @(negedge CLK);
    check("midrst_dsi", DSI, 0);
    check("midrst_di", DI, 0);
    check("midrst_res_valid", RES_VALID, 0);
    check("midrst_res_data", RES_DATA, 0);
    check("midrst_timeout_err", TIMEOUT_ERR, 0);
    check("midrst_win_ready", WIN_READY, 1);
    last_res = '0;
    $display("mid-SEND reset at cycle %0d done (checks=%0d)", hs + 4, checks);

    run_vector(0);

    check("pix_q_empty", pix_q.size(), 0);
    check("res_q_empty", res_q.size(), 0);
    check("total_timeouts", to_count, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
